vga_timing_monitor: RTL and testbench
=====================================

Name: vga_timing_monitor

Overview:
- Receive-side checker for the VGA sync outputs that the board wrapper drives.
- Samples hsync/vsync in the pixel clock domain and measures line period, hsync width, lines per frame and vsync width.
- Compares each measurement against the expected 640x480 timing and reports lock, loss of signal and an error count on the DE0-Nano LEDs.
- Sits beside the game instance, tapping the same hsync/vsync nets; it can also be pointed at external GPIO sync inputs.

Parameters:
- EXP_H_TOTAL, 800: expected clocks per line.
- EXP_H_SYNC, 96: expected hsync asserted width in clocks.
- EXP_V_TOTAL, 525: expected hsync assertions per frame.
- EXP_V_SYNC, 2: expected hsync assertions counted while vsync is asserted.
- LOCK_FRAMES, 2: consecutive good frames required to assert locked (1..15).
- SYNC_ACTIVE_LOW, 1: 1 means both syncs assert low.

Ports:
- clk, input, 1: pixel clock (25 MHz).
- reset_n, input, 1: asynchronous active-low reset.
- hsync, input, 1: raw horizontal sync.
- vsync, input, 1: raw vertical sync.
- line_len, output, 11: last measured line period in clocks.
- hsync_width, output, 11: last measured hsync asserted width in clocks.
- frame_lines, output, 10: last measured lines per frame.
- vsync_lines, output, 10: last measured vsync width in lines.
- frame_tick, output, 1: one-cycle pulse when a frame measurement completes.
- locked, output, 1: timing matches expectations.
- no_signal, output, 1: hsync absent.
- error_count, output, 8: saturating count of lock losses.

Behaviour:
- Reset values: all outputs 0, except no_signal = 1. The state machine resets to SEARCH.
- Reset is asynchronous assert, synchronous release. Asserting reset mid-frame discards every partial measurement.
- Input conditioning:
  - Each sync passes through a 2-FF synchroniser, then a third delay FF.
  - Inputs are inverted when SYNC_ACTIVE_LOW = 1, so internal "asserted" is always 1.
  - An assert edge is detected when the synchronised value is 1 and the delayed value is 0. The deassert edge is the reverse.
- Latency: a registered output changes on the 3rd rising clk after the raw pin transition is first sampled.
- h_cnt (11 bits):
  - Cleared on an hsync assert edge, otherwise increments, saturating at 2047.
  - On an assert edge with h_seen = 1: line_len <= h_cnt + 1.
  - The first assert edge after SEARCH only sets h_seen and does not update line_len.
- hw_cnt:
  - Cleared on an hsync assert edge and increments while asserted.
  - On a deassert edge: hsync_width <= hw_cnt + 1, provided an assert edge was seen since SEARCH.
- Vertical counters:
  - v_cnt counts hsync assert edges and vs_cnt counts hsync assert edges while vsync is asserted.
  - On a vsync assert edge: latch frame_lines <= v_cnt and vsync_lines <= vs_cnt (from the previous frame), pulse frame_tick, then clear both counters.
  - When both edges occur in the same cycle, the hsync edge is counted into the frame that is closing.
  - Both counters saturate at 1023.
- line_bad: sticky per frame. Set on any latched line_len != EXP_H_TOTAL or hsync_width != EXP_H_SYNC. Cleared at the vsync assert edge after evaluation.
- good_frame: true when line_bad = 0, frame_lines = EXP_V_TOTAL and vsync_lines = EXP_V_SYNC.
- State machine, evaluated on vsync assert edges:
  - SEARCH: wait for the first vsync assert edge, then go to MEASURE without evaluating.
  - MEASURE: a good frame increments good_cnt; a bad frame clears it. When good_cnt reaches LOCK_FRAMES, go to LOCKED and set locked = 1.
  - LOCKED: a bad frame clears locked and good_cnt, increments error_count (saturating at 255) and returns to MEASURE.
- Timeout: when h_cnt reaches 2047 in any state:
  - Set no_signal = 1 and locked = 0, and go to SEARCH.
  - Clear h_seen, good_cnt, line_bad and the vertical counters. Latched measurements hold their values.
  - error_count increments only if the block was LOCKED.
  - no_signal clears on the next hsync assert edge.
- All arithmetic is unsigned. Saturating counters never wrap.

Test Plan:
- Nominal 800x525 timing, hsync width 96, vsync width 2 lines, active-low:
  - First frame_tick one frame after the first vsync edge.
  - locked = 1 at the 3rd vsync assert edge; line_len = 800, hsync_width = 96, frame_lines = 525, vsync_lines = 2, error_count = 0.
- Locked, then a single line of 801 clocks: locked falls at the next vsync edge, error_count = 1, relock after 2 further good frames.
- Locked, then hsync held deasserted: no_signal = 1 and locked = 0 at 2047 clocks after the last edge, error_count = 1. Restarting sync relocks.
- vsync width of 3 lines, everything else nominal: vsync_lines = 3, locked never asserts, error_count stays 0.
- SYNC_ACTIVE_LOW = 0 with inverted nominal stimulus: same results as the nominal case. Active-low stimulus into this configuration: hsync_width = 704, no lock.
- reset_n pulsed mid-frame while locked: outputs return to reset values immediately, asynchronously. Lock is reacquired after the first vsync edge plus 2 good frames.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// -----------------------------------------------------------------------------
// vga_timing_monitor
//
// Receive-side checker for VGA sync signals. It samples hsync/vsync in the
// pixel clock domain, measures line period, hsync width, lines per frame and
// vsync width, then compares each completed frame against the expected timing.
// After enough consecutive good frames it reports lock. It reports loss of
// signal when hsync stops, and counts every loss of lock in a saturating
// error counter.
//
// Ports
//   clk          pixel clock
//   reset_n      asynchronous active-low reset (assert async, release sync)
//   hsync        raw horizontal sync
//   vsync        raw vertical sync
//   line_len     last measured line period, clocks
//   hsync_width  last measured hsync asserted width, clocks
//   frame_lines  last measured lines per frame (hsync assertions)
//   vsync_lines  last measured vsync width, lines (hsync assertions)
//   frame_tick   one-cycle pulse when a frame measurement is latched
//   locked       timing matches expectations
//   no_signal    hsync absent for 2047 clocks (set out of reset)
//   error_count  saturating count of lock losses
// -----------------------------------------------------------------------------
module vga_timing_monitor #(
    parameter int unsigned EXP_H_TOTAL     = 800,
    parameter int unsigned EXP_H_SYNC      = 96,
    parameter int unsigned EXP_V_TOTAL     = 525,
    parameter int unsigned EXP_V_SYNC      = 2,
    parameter int unsigned LOCK_FRAMES     = 2,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hsync,
    input  logic        vsync,
    output logic [10:0] line_len,
    output logic [10:0] hsync_width,
    output logic [9:0]  frame_lines,
    output logic [9:0]  vsync_lines,
    output logic        frame_tick,
    output logic        locked,
    output logic        no_signal,
    output logic [7:0]  error_count
);

    localparam logic [10:0] H_MAX  = 11'h7FF;
    localparam logic [9:0]  V_MAX  = 10'h3FF;
    localparam logic [7:0]  E_MAX  = 8'hFF;
    localparam logic [10:0] EXP_HT = 11'(EXP_H_TOTAL);
    localparam logic [10:0] EXP_HW = 11'(EXP_H_SYNC);
    localparam logic [9:0]  EXP_VT = 10'(EXP_V_TOTAL);
    localparam logic [9:0]  EXP_VS = 10'(EXP_V_SYNC);
    localparam logic [4:0]  LOCK_N = 5'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Input conditioning: polarity normalisation, 2-FF synchroniser, then a
    // delay stage for edge detection. Bit 0 is hsync, bit 1 is vsync.
    // Internally "1" always means asserted.
    // -------------------------------------------------------------------------
    logic [1:0] pin_raw;
    logic [1:0] pin_pol;
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;
    logic [1:0] dly_reg;
    logic [1:0] rise;

    assign pin_raw = {vsync, hsync};
    assign pin_pol = (SYNC_ACTIVE_LOW != 0) ? ~pin_raw : pin_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= 2'b00;
            sync_reg <= 2'b00;
            dly_reg  <= 2'b00;
        end else begin
            meta_reg <= pin_pol;
            sync_reg <= meta_reg;
            dly_reg  <= sync_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            assign rise[gi] = sync_reg[gi] & ~dly_reg[gi];
        end
    endgenerate

    logic hs_rise;
    logic hs_fall;
    logic hs_act;
    logic vs_rise;
    logic vs_act;

    assign hs_rise = rise[0];
    assign hs_fall = ~sync_reg[0] & dly_reg[0];
    assign hs_act  = sync_reg[0];
    assign vs_rise = rise[1];
    assign vs_act  = sync_reg[1];

    // -------------------------------------------------------------------------
    // Measurement state
    // -------------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [10:0] h_cnt_reg, h_cnt_next;
    logic [10:0] hw_cnt_reg, hw_cnt_next;
    logic        h_seen_reg, h_seen_next;
    logic [10:0] line_len_reg, line_len_next;
    logic [10:0] hsync_width_reg, hsync_width_next;
    logic [9:0]  v_cnt_reg, v_cnt_next;
    logic [9:0]  vs_cnt_reg, vs_cnt_next;
    logic [9:0]  frame_lines_reg, frame_lines_next;
    logic [9:0]  vsync_lines_reg, vsync_lines_next;
    logic        frame_tick_reg, frame_tick_next;
    logic        line_bad_reg, line_bad_next;
    logic [3:0]  good_cnt_reg, good_cnt_next;
    logic        locked_reg, locked_next;
    logic        no_signal_reg, no_signal_next;
    logic [7:0]  error_count_reg, error_count_next;

    // Saturating increments; the measured value is the counter plus one
    // because the counter is cleared on the edge cycle itself.
    logic [10:0] h_cnt_inc;
    logic [10:0] hw_cnt_inc;
    logic [9:0]  v_sum;
    logic [9:0]  vs_sum;
    logic        line_upd;
    logic        width_upd;
    logic        new_bad;
    logic        line_bad_now;
    logic        good_frame;
    logic        timeout;
    logic [4:0]  good_cnt_inc;
    logic        lock_reached;

    assign h_cnt_inc  = (h_cnt_reg  == H_MAX) ? H_MAX : h_cnt_reg  + 11'd1;
    assign hw_cnt_inc = (hw_cnt_reg == H_MAX) ? H_MAX : hw_cnt_reg + 11'd1;

    // An hsync edge in the same cycle as a vsync edge belongs to the frame
    // that is closing, so the closing totals include it.
    assign v_sum  = (hs_rise && (v_cnt_reg != V_MAX)) ? v_cnt_reg + 10'd1 : v_cnt_reg;
    assign vs_sum = (hs_rise && vs_act && (vs_cnt_reg != V_MAX)) ? vs_cnt_reg + 10'd1
                                                                 : vs_cnt_reg;

    // The first assert edge after SEARCH only arms the measurement.
    assign line_upd  = hs_rise & h_seen_reg;
    assign width_upd = hs_fall & h_seen_reg;

    assign new_bad      = (line_upd  && (h_cnt_inc  != EXP_HT)) ||
                          (width_upd && (hw_cnt_inc != EXP_HW));
    assign line_bad_now = line_bad_reg | new_bad;
    assign good_frame   = !line_bad_now && (v_sum == EXP_VT) && (vs_sum == EXP_VS);

    // A coincident assert edge means hsync is still alive, so it wins.
    assign timeout = (h_cnt_reg == H_MAX) && !hs_rise;

    assign good_cnt_inc = {1'b0, good_cnt_reg} + 5'd1;
    assign lock_reached = good_frame && (good_cnt_inc >= LOCK_N);

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        h_cnt_next       = hs_rise ? 11'd0 : h_cnt_inc;
        hw_cnt_next      = hs_rise ? 11'd0 : (hs_act ? hw_cnt_inc : hw_cnt_reg);
        h_seen_next      = h_seen_reg;
        line_len_next    = line_upd  ? h_cnt_inc  : line_len_reg;
        hsync_width_next = width_upd ? hw_cnt_inc : hsync_width_reg;
        v_cnt_next       = v_sum;
        vs_cnt_next      = vs_sum;
        frame_lines_next = frame_lines_reg;
        vsync_lines_next = vsync_lines_reg;
        frame_tick_next  = 1'b0;
        line_bad_next    = line_bad_now;

        if (hs_rise) begin
            h_seen_next = 1'b1;
        end

        if (timeout) begin
            // Latched measurements are kept; everything in flight is dropped.
            h_seen_next   = 1'b0;
            v_cnt_next    = 10'd0;
            vs_cnt_next   = 10'd0;
            line_bad_next = 1'b0;
        end else if (vs_rise) begin
            v_cnt_next    = 10'd0;
            vs_cnt_next   = 10'd0;
            line_bad_next = 1'b0;
            // The vsync edge that leaves SEARCH closes no complete frame.
            if (state_reg != S_SEARCH) begin
                frame_lines_next = v_sum;
                vsync_lines_next = vs_sum;
                frame_tick_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_reg       <= 11'd0;
            hw_cnt_reg      <= 11'd0;
            h_seen_reg      <= 1'b0;
            line_len_reg    <= 11'd0;
            hsync_width_reg <= 11'd0;
            v_cnt_reg       <= 10'd0;
            vs_cnt_reg      <= 10'd0;
            frame_lines_reg <= 10'd0;
            vsync_lines_reg <= 10'd0;
            frame_tick_reg  <= 1'b0;
            line_bad_reg    <= 1'b0;
        end else begin
            h_cnt_reg       <= h_cnt_next;
            hw_cnt_reg      <= hw_cnt_next;
            h_seen_reg      <= h_seen_next;
            line_len_reg    <= line_len_next;
            hsync_width_reg <= hsync_width_next;
            v_cnt_reg       <= v_cnt_next;
            vs_cnt_reg      <= vs_cnt_next;
            frame_lines_reg <= frame_lines_next;
            vsync_lines_reg <= vsync_lines_next;
            frame_tick_reg  <= frame_tick_next;
            line_bad_reg    <= line_bad_next;
        end
    end

    // -------------------------------------------------------------------------
    // Lock state machine: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_SEARCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Lock state machine: next state. Frames are judged only at vsync edges.
    always_comb begin
        state_next = state_reg;
        if (timeout) begin
            state_next = S_SEARCH;
        end else if (vs_rise) begin
            case (state_reg)
                S_SEARCH:  state_next = S_MEASURE;
                S_MEASURE: if (lock_reached) state_next = S_LOCKED;
                S_LOCKED:  if (!good_frame)  state_next = S_MEASURE;
                default:   state_next = S_SEARCH;
            endcase
        end
    end

    // Lock state machine: outputs (registered below)
    always_comb begin
        locked_next      = locked_reg;
        good_cnt_next    = good_cnt_reg;
        error_count_next = error_count_reg;
        no_signal_next   = no_signal_reg;

        if (hs_rise) begin
            no_signal_next = 1'b0;
        end

        if (timeout) begin
            no_signal_next = 1'b1;
            locked_next    = 1'b0;
            good_cnt_next  = 4'd0;
            if ((state_reg == S_LOCKED) && (error_count_reg != E_MAX)) begin
                error_count_next = error_count_reg + 8'd1;
            end
        end else if (vs_rise) begin
            case (state_reg)
                S_MEASURE: begin
                    if (good_frame) begin
                        good_cnt_next = good_cnt_inc[3:0];
                        if (lock_reached) begin
                            locked_next = 1'b1;
                        end
                    end else begin
                        good_cnt_next = 4'd0;
                    end
                end
                S_LOCKED: begin
                    if (!good_frame) begin
                        locked_next   = 1'b0;
                        good_cnt_next = 4'd0;
                        if (error_count_reg != E_MAX) begin
                            error_count_next = error_count_reg + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked_reg      <= 1'b0;
            good_cnt_reg    <= 4'd0;
            error_count_reg <= 8'd0;
            no_signal_reg   <= 1'b1;
        end else begin
            locked_reg      <= locked_next;
            good_cnt_reg    <= good_cnt_next;
            error_count_reg <= error_count_next;
            no_signal_reg   <= no_signal_next;
        end
    end

    assign line_len    = line_len_reg;
    assign hsync_width = hsync_width_reg;
    assign frame_lines = frame_lines_reg;
    assign vsync_lines = vsync_lines_reg;
    assign frame_tick  = frame_tick_reg;
    assign locked      = locked_reg;
    assign no_signal   = no_signal_reg;
    assign error_count = error_count_reg;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_monitor
//
// Directed bench. The raster is scaled down (64 clocks/line, 8-clock hsync,
// 12 lines/frame, 2-line vsync) so many frames fit in a short run; the
// timeout threshold of 2047 clocks is unscaled.
//   dut_a : active-low config, active-low raster
//   dut_b : active-high config, inverted raster (must match dut_a)
//   dut_c : active-high config, active-low raster (wrong polarity)
// -----------------------------------------------------------------------------
module tb_vga_timing_monitor;

    localparam int HT  = 64;  // clocks per line
    localparam int HW  = 8;   // hsync width
    localparam int HS0 = 50;  // hsync start within a line
    localparam int VT  = 12;  // lines per frame
    localparam int VS0 = 9;   // vsync start line

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic hs_lo, vs_lo;
    logic hs_hi, vs_hi;
    assign hs_hi = ~hs_lo;
    assign vs_hi = ~vs_lo;

    logic [10:0] a_line_len, a_hsync_width, b_line_len, b_hsync_width, c_line_len, c_hsync_width;
    logic [9:0]  a_frame_lines, a_vsync_lines, b_frame_lines, b_vsync_lines, c_frame_lines, c_vsync_lines;
    logic        a_frame_tick, a_locked, a_no_signal;
    logic        b_frame_tick, b_locked, b_no_signal;
    logic        c_frame_tick, c_locked, c_no_signal;
    logic [7:0]  a_error_count, b_error_count, c_error_count;

    vga_timing_monitor #(
        .EXP_H_TOTAL(HT), .EXP_H_SYNC(HW), .EXP_V_TOTAL(VT), .EXP_V_SYNC(2),
        .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .hsync(hs_lo), .vsync(vs_lo),
        .line_len(a_line_len), .hsync_width(a_hsync_width),
        .frame_lines(a_frame_lines), .vsync_lines(a_vsync_lines),
        .frame_tick(a_frame_tick), .locked(a_locked),
        .no_signal(a_no_signal), .error_count(a_error_count)
    );

    vga_timing_monitor #(
        .EXP_H_TOTAL(HT), .EXP_H_SYNC(HW), .EXP_V_TOTAL(VT), .EXP_V_SYNC(2),
        .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .hsync(hs_hi), .vsync(vs_hi),
        .line_len(b_line_len), .hsync_width(b_hsync_width),
        .frame_lines(b_frame_lines), .vsync_lines(b_vsync_lines),
        .frame_tick(b_frame_tick), .locked(b_locked),
        .no_signal(b_no_signal), .error_count(b_error_count)
    );

    vga_timing_monitor #(
        .EXP_H_TOTAL(HT), .EXP_H_SYNC(HW), .EXP_V_TOTAL(VT), .EXP_V_SYNC(2),
        .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(0)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .hsync(hs_lo), .vsync(vs_lo),
        .line_len(c_line_len), .hsync_width(c_hsync_width),
        .frame_lines(c_frame_lines), .vsync_lines(c_vsync_lines),
        .frame_tick(c_frame_tick), .locked(c_locked),
        .no_signal(c_no_signal), .error_count(c_error_count)
    );

    // A pulse longer than one cycle would be counted more than once.
    int tick_a = 0;
    always @(posedge clk) begin
        if (a_frame_tick === 1'b1) tick_a <= tick_a + 1;
    end

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-20s observed %0d expected %0d", tag, obs, exp);
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Active-low raster lines [0, n_lines); long_line gets one extra clock.
    task automatic gen_lines(input int vs_lines, input int long_line, input int n_lines);
        int len;
        for (int ln = 0; ln < n_lines; ln++) begin
            len = (ln == long_line) ? HT + 1 : HT;
            for (int h = 0; h < len; h++) begin
                @(negedge clk);
                hs_lo = !((h >= HS0) && (h < HS0 + HW));
                vs_lo = !((ln >= VS0) && (ln < VS0 + vs_lines));
            end
        end
    endtask

    task automatic gen_frame(input int vs_lines, input int long_line);
        gen_lines(vs_lines, long_line, VT);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hs_lo = 1'b1;
            vs_lo = 1'b1;
        end
    endtask

    int t0;

    initial begin
        hs_lo   = 1'b1;
        vs_lo   = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);

        // ---- reset values ----
        check("rst_no_signal",   a_no_signal,   1);
        check("rst_locked",      a_locked,      0);
        check("rst_line_len",    a_line_len,    0);
        check("rst_hsync_width", a_hsync_width, 0);
        check("rst_frame_lines", a_frame_lines, 0);
        check("rst_vsync_lines", a_vsync_lines, 0);
        check("rst_frame_tick",  a_frame_tick,  0);
        check("rst_error_count", a_error_count, 0);
        reset_n = 1'b1;

        // ---- nominal timing ----
        gen_frame(2, -1);
        check("f1_ticks",     tick_a,      0);
        check("f1_no_signal", a_no_signal, 0);
        check("f1_locked",    a_locked,    0);
        gen_frame(2, -1);
        check("f2_ticks",       tick_a,        1);
        check("f2_frame_lines", a_frame_lines, VT);
        check("f2_locked",      a_locked,      0);
        gen_frame(2, -1);
        check("f3_ticks",       tick_a,        2);
        check("f3_locked",      a_locked,      1);
        check("f3_line_len",    a_line_len,    HT);
        check("f3_hsync_width", a_hsync_width, HW);
        check("f3_frame_lines", a_frame_lines, VT);
        check("f3_vsync_lines", a_vsync_lines, 2);
        check("f3_error_count", a_error_count, 0);
        check("b_locked",       b_locked,      1);
        check("b_line_len",     b_line_len,    HT);
        check("b_hsync_width",  b_hsync_width, HW);
        check("b_frame_lines",  b_frame_lines, VT);
        check("b_vsync_lines",  b_vsync_lines, 2);
        check("c_hsync_width",  c_hsync_width, HT - HW);
        check("c_vsync_lines",  c_vsync_lines, VT - 2);
        check("c_locked",       c_locked,      0);

        // ---- one long line while locked ----
        gen_frame(2, 3);
        check("long_locked",      a_locked,      0);
        check("long_error_count", a_error_count, 1);
        check("long_line_len",    a_line_len,    HT);
        gen_frame(2, -1);
        check("relock1_locked", a_locked, 0);
        gen_frame(2, -1);
        check("relock2_locked", a_locked,      1);
        check("relock2_errors", a_error_count, 1);
        check("c_error_count",  c_error_count, 0);

        // ---- asynchronous reset mid-frame while locked ----
        gen_lines(2, -1, 5);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_locked",      a_locked,      0);
        check("arst_no_signal",   a_no_signal,   1);
        check("arst_line_len",    a_line_len,    0);
        check("arst_frame_lines", a_frame_lines, 0);
        check("arst_error_count", a_error_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        gen_frame(2, -1);
        gen_frame(2, -1);
        check("arst_f2_locked", a_locked, 0);
        gen_frame(2, -1);
        check("arst_f3_locked", a_locked,      1);
        check("arst_f3_errors", a_error_count, 0);

        // ---- hsync lost while locked ----
        idle(1900);
        check("pre_to_no_signal", a_no_signal, 0);
        check("pre_to_locked",    a_locked,    1);
        idle(200);
        check("to_no_signal",   a_no_signal,   1);
        check("to_locked",      a_locked,      0);
        check("to_error_count", a_error_count, 1);
        check("to_line_len",    a_line_len,    HT);
        check("to_frame_lines", a_frame_lines, VT);
        check("b_to_errors",    b_error_count, 1);
        gen_frame(2, -1);
        check("rs_no_signal", a_no_signal, 0);
        gen_frame(2, -1);
        gen_frame(2, -1);
        check("rs_locked",      a_locked,      1);
        check("rs_error_count", a_error_count, 1);

        // ---- input latency, then 3-line vsync ----
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        hs_lo = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("lat_edge2_no_signal", a_no_signal, 1);
        @(posedge clk); #1;
        check("lat_edge3_no_signal", a_no_signal, 0);
        @(negedge clk);
        hs_lo = 1'b1;
        t0 = tick_a;
        for (int f = 0; f < 4; f++) gen_frame(3, -1);
        check("vs3_ticks",       tick_a - t0,   3);
        check("vs3_vsync_lines", a_vsync_lines, 3);
        check("vs3_frame_lines", a_frame_lines, VT);
        check("vs3_locked",      a_locked,      0);
        check("vs3_error_count", a_error_count, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
